// File: rtl/ysyx_22041752_divider.sv
// Radix-2 restoring divider for the RV64M divide group (DIV/DIVU/REM/REMU and
// their W forms). Operands are converted to magnitudes at accept. One trial
// subtraction runs per BUSY cycle, and the sign fixup is applied on entry to
// DONE so that quotient/remainder are already valid while out_valid is high.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | div_ready high, waiting for a request
// S_BUSY | one quotient bit per cycle, cnt_q iterations left
// S_DONE | results valid, out_valid pulses for this single cycle
module ysyx_22041752_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        div_valid,
   output logic        div_ready,
   input  logic        div_signed,
   input  logic        div_word,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   output logic        out_valid,
   output logic [63:0] quotient,
   output logic [63:0] remainder
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [64:0] rem_q, rem_d;        // partial remainder
   logic [63:0] quo_q, quo_d;        // dividend bits shift out the top, quotient bits shift in below
   logic [63:0] dvs_q, dvs_d;        // divisor magnitude
   logic [6:0]  cnt_q, cnt_d;        // iterations remaining
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        word_q, word_d;
   logic [63:0] quotient_q, quotient_d;
   logic [63:0] remainder_q, remainder_d;

   logic [63:0] eff_a, eff_b, abs_a, abs_b;
   logic        neg_a, neg_b, div_zero, sig_ovf;
   logic [64:0] r_shift, diff, rem_step;
   logic [63:0] quo_step, q_fix, r_fix;
   logic        q_bit;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Effective operands, magnitudes and special-case detection at accept
   always_comb begin
      eff_a = dividend;
      eff_b = divisor;
      if (div_word) begin
         eff_a = div_signed ? sext32(dividend[31:0]) : {32'd0, dividend[31:0]};
         eff_b = div_signed ? sext32(divisor[31:0])  : {32'd0, divisor[31:0]};
      end
      neg_a    = div_signed & eff_a[63];
      neg_b    = div_signed & eff_b[63];
      abs_a    = neg_a ? (64'd0 - eff_a) : eff_a;
      abs_b    = neg_b ? (64'd0 - eff_b) : eff_b;
      div_zero = (eff_b == 64'd0);
      sig_ovf  = div_signed && (eff_b == {64{1'b1}}) &&
                 (eff_a == (div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
   end

   // One restoring step plus the signed/word fixup of its result.
   // r_shift < 2*divisor keeps a non-negative diff below 2^64, so bit 64 is the sign.
   always_comb begin
      r_shift  = {rem_q[63:0], quo_q[63]};
      diff     = r_shift - {1'b0, dvs_q};
      q_bit    = ~diff[64];
      rem_step = q_bit ? diff : r_shift;
      quo_step = {quo_q[62:0], q_bit};
      q_fix    = neg_quo_q ? (64'd0 - quo_step) : quo_step;
      r_fix    = neg_rem_q ? (64'd0 - rem_step[63:0]) : rem_step[63:0];
      if (word_q) begin
         q_fix = sext32(q_fix[31:0]);
         r_fix = sext32(r_fix[31:0]);
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      word_d      = word_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      case (state_q)
         S_IDLE: begin
            if (div_valid && !flush) begin
               word_d    = div_word;
               neg_quo_d = neg_a ^ neg_b;
               neg_rem_d = neg_a;
               dvs_d     = abs_b;
               rem_d     = 65'd0;
               // W ops pre-align the 32 live dividend bits to the top of the shifter
               quo_d     = div_word ? {abs_a[31:0], 32'd0} : abs_a;
               cnt_d     = div_word ? 7'd32 : 7'd64;
               if (div_zero) begin
                  state_d     = S_DONE;
                  quotient_d  = {64{1'b1}};
                  remainder_d = div_word ? sext32(eff_a[31:0]) : eff_a;
               end else if (sig_ovf) begin
                  state_d     = S_DONE;
                  quotient_d  = eff_a;
                  remainder_d = 64'd0;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
               state_d     = S_DONE;
               quotient_d  = q_fix;
               remainder_d = r_fix;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d     = S_IDLE;
         quotient_d  = quotient_q;
         remainder_d = remainder_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rem_q       <= 65'd0;
         quo_q       <= 64'd0;
         dvs_q       <= 64'd0;
         cnt_q       <= 7'd0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         word_q      <= 1'b0;
         quotient_q  <= 64'd0;
         remainder_q <= 64'd0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         word_q      <= word_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign div_ready = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22041752_divider.sv
// Self-checking bench for ysyx_22041752_divider: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_ysyx_22041752_divider;

   logic        clk = 1'b0;
   logic        reset, flush, div_valid, div_signed, div_word;
   logic [63:0] dividend, divisor;
   logic        div_ready, out_valid;
   logic [63:0] quotient, remainder;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   ysyx_22041752_divider dut (
      .clk(clk), .reset(reset), .flush(flush), .div_valid(div_valid),
      .div_ready(div_ready), .div_signed(div_signed), .div_word(div_word),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // RISC-V division semantics computed with plain arithmetic
   function automatic void model(input logic sg, input logic wd, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] q,
                                 output logic [63:0] r, output int lat);
      logic [31:0] a32, b32, q32, r32;
      longint      sa, sb;
      int          sa32, sb32;
      lat = wd ? 33 : 65;
      a32 = a[31:0];
      b32 = b[31:0];
      if (!wd) begin
         if (b == 64'd0) begin q = ONES; r = a; lat = 1; end
         else if (sg && a == 64'h8000_0000_0000_0000 && b == ONES) begin q = a; r = 64'd0; lat = 1; end
         else if (sg) begin sa = a; sb = b; q = sa / sb; r = sa % sb; end
         else begin q = a / b; r = a % b; end
      end else begin
         if (b32 == 32'd0) begin q = ONES; r = {{32{a32[31]}}, a32}; lat = 1; end
         else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q = {{32{1'b1}}, a32}; r = 64'd0; lat = 1;
         end else begin
            if (sg) begin sa32 = a32; sb32 = b32; q32 = sa32 / sb32; r32 = sa32 % sb32; end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
         end
      end
   endfunction

   // Issues one request in the current cycle (cycle 0), waits for out_valid and
   // returns the cycle in which it appeared; ends in the following cycle.
   task automatic run_op(input logic sg, input logic wd, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
      div_valid = 1'b1; div_signed = sg; div_word = wd; dividend = a; divisor = b;
      @(posedge clk); #1;
      div_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      q = quotient;
      r = remainder;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", div_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (quotient !== 64'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
      checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
   endtask

   task automatic test_divu;
      int lat;
      logic busy_ready_seen;
      div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0; dividend = 64'd100; divisor = 64'd7;
      @(posedge clk); #1;
      // Divide-by-zero request while BUSY must be ignored
      dividend = 64'd5; divisor = 64'd0;
      lat = 1;
      busy_ready_seen = 1'b0;
      while (!out_valid && lat < 200) begin
         if (lat <= 5 && div_ready) busy_ready_seen = 1'b1;
         if (lat == 5) div_valid = 1'b0;
         @(posedge clk); #1; lat++;
      end
      checks++; if (busy_ready_seen !== 1'b0) begin errors++; $display("FAIL divu_busy_ready got 1 want 0"); end
      checks++; if (lat != 65) begin errors++; $display("FAIL divu_latency got %0d want 65", lat); end
      checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL divu_quotient got %h want 14", quotient); end
      checks++; if (remainder !== 64'd2) begin errors++; $display("FAIL divu_remainder got %h want 2", remainder); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || div_ready !== 1'b1)
         begin errors++; $display("FAIL divu_after got valid=%b ready=%b want 0/1", out_valid, div_ready); end
   endtask

   task automatic test_signed;
      logic [63:0] q, r; int lat;
      run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, q, r, lat);
      checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2_q got %h want fffffffffffffffd", q); end
      checks++; if (r !== ONES) begin errors++; $display("FAIL div_m7_2_r got %h want ffffffffffffffff", r); end
      checks++; if (lat != 65) begin errors++; $display("FAIL div_m7_2_lat got %0d want 65", lat); end
      run_op(1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, q, r, lat);
      checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_7_m2_q got %h want fffffffffffffffd", q); end
      checks++; if (r !== 64'd1) begin errors++; $display("FAIL div_7_m2_r got %h want 1", r); end
   endtask

   task automatic test_div_zero;
      logic [63:0] q, r; int lat;
      run_op(1'b0, 1'b0, 64'h1234, 64'd0, q, r, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL dz_lat got %0d want 1", lat); end
      checks++; if (q !== ONES) begin errors++; $display("FAIL dz_q got %h want all ones", q); end
      checks++; if (r !== 64'h1234) begin errors++; $display("FAIL dz_r got %h want 1234", r); end
      run_op(1'b1, 1'b1, 64'd5, 64'hABCD_0000_0000_0000, q, r, lat);
      checks++; if (q !== ONES) begin errors++; $display("FAIL dzw_q got %h want all ones", q); end
      checks++; if (r !== 64'd5) begin errors++; $display("FAIL dzw_r got %h want 5", r); end
      checks++; if (lat != 1) begin errors++; $display("FAIL dzw_lat got %0d want 1", lat); end
   endtask

   task automatic test_overflow;
      logic [63:0] q, r; int lat;
      run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, ONES, q, r, lat);
      checks++; if (q !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_q got %h want 8000000000000000", q); end
      checks++; if (r !== 64'd0) begin errors++; $display("FAIL ovf_r got %h want 0", r); end
      checks++; if (lat != 1) begin errors++; $display("FAIL ovf_lat got %0d want 1", lat); end
      run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, ONES, q, r, lat);
      checks++; if (q !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ovfw_q got %h want ffffffff80000000", q); end
      checks++; if (r !== 64'd0) begin errors++; $display("FAIL ovfw_r got %h want 0", r); end
      checks++; if (lat != 1) begin errors++; $display("FAIL ovfw_lat got %0d want 1", lat); end
   endtask

   task automatic test_word;
      logic [63:0] q, r; int lat;
      run_op(1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE, 64'd2, q, r, lat);
      checks++; if (q !== 64'h0000_0000_7FFF_FFFF) begin errors++; $display("FAIL divuw_q got %h want 7fffffff", q); end
      checks++; if (r !== 64'd0) begin errors++; $display("FAIL divuw_r got %h want 0", r); end
      checks++; if (lat != 33) begin errors++; $display("FAIL divuw_lat got %0d want 33", lat); end
      run_op(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4, q, r, lat);
      checks++; if (r !== ONES) begin errors++; $display("FAIL remw_r got %h want all ones", r); end
      checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL remw_q got %h want fffffffffffffffe", q); end
   endtask

   task automatic test_random;
      logic [63:0] a, b, q, r, eq, er; int lat, elat, mode; logic sg, wd;
      for (int i = 0; i < 30; i++) begin
         sg = 1'($urandom_range(0, 1));
         wd = 1'($urandom_range(0, 1));
         a = {$urandom, $urandom};
         mode = $urandom_range(0, 5);
         case (mode)
            0: b = {$urandom, $urandom};
            1: b = 64'($urandom_range(1, 1000));
            2: b = {$urandom, $urandom} >> $urandom_range(0, 63);
            3: b = wd ? {$urandom, 32'd0} : 64'd0;
            4: begin
                  sg = 1'b1;
                  a = wd ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                  b = wd ? {$urandom, 32'hFFFF_FFFF} : ONES;
               end
            default: b = 64'd0 - 64'($urandom_range(1, 50));
         endcase
         model(sg, wd, a, b, eq, er, elat);
         run_op(sg, wd, a, b, q, r, lat);
         checks++; if (q !== eq) begin errors++; $display("FAIL rand%0d_q s=%b w=%b a=%h b=%h got %h want %h", i, sg, wd, a, b, q, eq); end
         checks++; if (r !== er) begin errors++; $display("FAIL rand%0d_r s=%b w=%b a=%h b=%h got %h want %h", i, sg, wd, a, b, r, er); end
         checks++; if (lat != elat) begin errors++; $display("FAIL rand%0d_lat got %0d want %0d", i, lat, elat); end
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] q, r, eq, er; int lat, elat, c0, c1, c2;
      c0 = cyc;
      run_op(1'b0, 1'b0, 64'd1000, 64'd9, q, r, lat);
      c1 = cyc;
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", div_ready); end
      run_op(1'b1, 1'b1, 64'h0000_0000_FFFF_FF00, 64'd3, q, r, lat);
      c2 = cyc;
      run_op(1'b0, 1'b0, 64'd77, 64'd0, q, r, lat);
      model(1'b0, 1'b0, 64'd77, 64'd0, eq, er, elat);
      checks++; if (c1 - c0 != 66) begin errors++; $display("FAIL b2b_gap64 got %0d want 66", c1 - c0); end
      checks++; if (c2 - c1 != 34) begin errors++; $display("FAIL b2b_gapw got %0d want 34", c2 - c1); end
      checks++; if (q !== eq || r !== er) begin errors++; $display("FAIL b2b_dz got %h/%h want %h/%h", q, r, eq, er); end
   endtask

   // Kills an op at cycle 10 with flush (use_reset=0) or reset (use_reset=1),
   // then accepts 20/6 at cycle 11 and expects it at cycle 76
   task automatic test_kill(input logic use_reset);
      int k; logic early_ov;
      // flush together with div_valid in IDLE must not accept
      flush = 1'b1; div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0; dividend = 64'd5; divisor = 64'd0;
      @(posedge clk); #1;
      flush = 1'b0; div_valid = 1'b0;
      checks++; if (div_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL flush_idle got ready=%b valid=%b want 1/0", div_ready, out_valid); end
      div_valid = 1'b1; div_signed = 1'b1; dividend = 64'd1000; divisor = 64'hFFFF_FFFF_FFFF_FFFD;
      @(posedge clk); #1;
      div_valid = 1'b0;
      early_ov = 1'b0;
      for (k = 1; k < 10; k++) begin
         if (out_valid) early_ov = 1'b1;
         @(posedge clk); #1;
      end
      if (use_reset) begin reset = 1'b1; div_valid = 1'b1; flush = 1'b1; end
      else flush = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0; div_valid = 1'b0;
      checks++; if (div_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL kill%0d_c11 got ready=%b valid=%b want 1/0", use_reset, div_ready, out_valid); end
      if (use_reset) begin
         checks++; if (quotient !== 64'd0 || remainder !== 64'd0)
            begin errors++; $display("FAIL kill_reset_vals got %h/%h want 0/0", quotient, remainder); end
      end
      div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0; dividend = 64'd20; divisor = 64'd6;
      @(posedge clk); #1;
      div_valid = 1'b0;
      k = 12;
      while (!out_valid && k < 300) begin @(posedge clk); #1; k++; end
      checks++; if (early_ov !== 1'b0 || k != 76)
         begin errors++; $display("FAIL kill%0d_latency got early=%b cycle=%0d want 0/76", use_reset, early_ov, k); end
      checks++; if (quotient !== 64'd3 || remainder !== 64'd2)
         begin errors++; $display("FAIL kill%0d_result got %h/%h want 3/2", use_reset, quotient, remainder); end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0; div_word = 1'b0;
      dividend = 64'd0; divisor = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_divu();
      test_signed();
      test_div_zero();
      test_overflow();
      test_word();
      test_random();
      test_back_to_back();
      test_kill(1'b0);
      test_kill(1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22041752_divider.md
# ysyx_22041752_divider

Iterative radix-2 restoring divider for the RV64M divide group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW. It sits beside the 64-bit adder/subtractor in the execute stage. The ALU hands it one operation through a valid/ready handshake. It returns quotient and remainder after a fixed, data-independent number of cycles. Each iteration is one 65-bit trial subtraction; it is the inverse-operation companion of the multiplier.

## Interface
- No parameters; datapath fixed at 64 bits.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clocked cycle returns block to IDLE
- flush  input  1  pipeline kill; abandons any in-flight operation
- div_valid  input  1  request present this cycle
- div_ready  output  1  block can accept a request (high only in IDLE)
- div_signed  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU
- div_word  input  1  1 = 32-bit W variant: use operand bits [31:0] only
- dividend  input  64  numerator
- divisor  input  64  denominator
- out_valid  output  1  one-cycle pulse; quotient/remainder valid this cycle
- quotient  output  64  result quotient, sign-extended from bit 31 when div_word
- remainder  output  64  result remainder, sign-extended from bit 31 when div_word

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE.** div_ready=1. On div_valid && !flush, capture the operands and move to BUSY, or to DONE for a special case.
- **Operand preparation at accept.**
  - When div_word=1, take bits [31:0], sign-extended if div_signed and zero-extended otherwise.
  - When div_signed=1, register the absolute values, plus sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
- **Special cases, detected at accept; no iterations are run.**
  - Divisor zero (of the effective width): quotient = all ones (64'hFFFF_FFFF_FFFF_FFFF), remainder = effective dividend.
  - Signed overflow, dividend = most negative value and divisor = -1: quotient = effective dividend, remainder = 0.
  - Word overflow uses 32-bit values (0x8000_0000 / 0xFFFF_FFFF).
- **BUSY.**
  - Iteration count N = 64, or 32 when div_word.
  - Each cycle: partial remainder R (65 bits) = {R[63:0], next dividend MSB}.
  - Trial difference D = R − {1'b0, |divisor|}.
  - If D ≥ 0: R = D and shift in quotient bit 1; otherwise keep R and shift in 0.
  - A 7-bit counter counts iterations; after the N-th iteration go to DONE.
- **DONE.**
  - Apply the sign fixup: negate the quotient if sign_q, and negate the remainder if sign_r.
  - When div_word, sign-extend both from bit 31; this applies to all W ops, including DIVUW and REMUW.
  - Assert out_valid for exactly this cycle and return to IDLE.
- **Outputs.** quotient and remainder are registered and hold their last value until the next DONE.
- **flush.** In any state, the next state is IDLE and out_valid is 0 in the following cycle. flush together with div_valid in IDLE does not accept the request.
- **Reset.** reset wins over flush and div_valid.
- **New requests.** A request is never accepted while BUSY or DONE.

## Timing
- Reset values: state = IDLE, div_ready = 1, out_valid = 0, quotient = 0, remainder = 0, counter = 0.
- Accept happens in cycle 0, the cycle in which div_valid && div_ready.
- Normal latency: out_valid in cycle N+1, i.e. cycle 65 for 64-bit ops and cycle 33 for W ops.
- Special-case latency: out_valid in cycle 1.
- div_ready deasserts from cycle 1 and reasserts in the cycle after the out_valid cycle.
- Back-to-back throughput is one operation per N+2 cycles.
- Reset or flush asserted in a BUSY cycle k: div_ready = 1 in cycle k+1, and no out_valid pulse follows.

## Test plan
- **Unsigned 64-bit DIVU.** 100 / 7 -> out_valid at cycle 65, quotient = 14, remainder = 2. A request presented during BUSY is ignored (div_ready = 0).
- **Signed DIV/REM.** -7 / 2 -> quotient = -3 (64'hFFFF_FFFF_FFFF_FFFD), remainder = -1. Also 7 / -2 -> quotient = -3, remainder = 1.
- **Divide by zero.** DIVU 0x1234 / 0 -> out_valid at cycle 1, quotient = 64'hFFFF_FFFF_FFFF_FFFF, remainder = 0x1234. Also DIVW 5 / 0 -> quotient all ones, remainder = 5.
- **Signed overflow.**
  - DIV 64'h8000_0000_0000_0000 / -1 -> quotient = 64'h8000_0000_0000_0000, remainder = 0, at cycle 1.
  - DIVW with dividend 0x8000_0000 / -1 -> quotient = 64'hFFFF_FFFF_8000_0000, remainder = 0.
- **Word ops.**
  - DIVUW with dividend 64'hDEAD_BEEF_FFFF_FFFE / 2 -> uses 0xFFFF_FFFE, quotient = 64'h0000_0000_7FFF_FFFF, remainder = 0, out_valid at cycle 33.
  - REMW -9 / 4 -> remainder = 64'hFFFF_FFFF_FFFF_FFFF.
- **Flush and reset mid-operation.**
  - Flush at cycle 10 of a DIV -> div_ready = 1 at cycle 11, and no out_valid through cycle 70.
  - A new 20 / 6 request accepted at cycle 11 -> quotient 3, remainder 2 at cycle 76.
  - Repeat with reset in place of flush and check the reset values.
